// File: rtl/lfsr_cipher_ctrl_if.sv
// lfsr_cipher_ctrl_if: job request, LFSR control and message/result RAM signals of the cipher sequencer
interface lfsr_cipher_ctrl_if #(parameter int AW = 6);
   logic          start;
   logic [7:0]    tap_i;
   logic [7:0]    seed_i;
   logic [AW-1:0] len_i;
   logic          lfsr_init;
   logic          lfsr_en;
   logic [7:0]    lfsr_tab;
   logic [7:0]    lfsr_init_state;
   logic [7:0]    lfsr_state;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          busy;
   logic          done;
   modport master (
      input  start, tap_i, seed_i, len_i, lfsr_state, rd_data,
      output lfsr_init, lfsr_en, lfsr_tab, lfsr_init_state, rd_addr, wr_en, wr_addr, wr_data, busy, done
   );
   modport slave (
      output start, tap_i, seed_i, len_i, lfsr_state, rd_data,
      input  lfsr_init, lfsr_en, lfsr_tab, lfsr_init_state, rd_addr, wr_en, wr_addr, wr_data, busy, done
   );
endinterface

// File: rtl/lfsr_cipher_ctrl.sv
// lfsr_cipher_ctrl: seeds an LFSR, discards warm-up states, then XORs a message buffer with the keystream
module lfsr_cipher_ctrl #(
   parameter int AW     = 6,
   parameter int WARMUP = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   lfsr_cipher_ctrl_if.master bus
);
   localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam logic [WW-1:0] WLAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
   typedef enum logic [2:0] {IDLE, LOAD, WARM, RD, WR, DONE} state_t;
   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d, len_q, len_d;
   logic [7:0]    tap_q, tap_d, seed_q, seed_d;
   logic [WW-1:0] warm_q, warm_d;
   // State and job parameters; reset abandons any job in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         tap_q   <= '0;
         seed_q  <= '0;
         warm_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         tap_q   <= tap_d;
         seed_q  <= seed_d;
         warm_q  <= warm_d;
      end
   end
   // Job sequencing: capture on start, load, warm up, then one RD/WR pair per byte
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      tap_d   = tap_q;
      seed_d  = seed_q;
      warm_d  = warm_q;
      case (state_q)
         IDLE: if (bus.start) begin
            tap_d   = bus.tap_i;
            seed_d  = bus.seed_i;
            len_d   = bus.len_i;
            idx_d   = '0;
            warm_d  = '0;
            state_d = LOAD;
         end
         LOAD: state_d = (WARMUP > 0) ? WARM : ((len_q != '0) ? RD : DONE);
         WARM: begin
            warm_d = warm_q + 1'b1;
            if (warm_q == WLAST) state_d = (len_q != '0) ? RD : DONE;
         end
         RD:   state_d = WR;
         WR: begin
            idx_d   = idx_q + 1'b1;
            state_d = (idx_q + 1'b1 < len_q) ? RD : DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign bus.lfsr_init       = state_q == LOAD;
   assign bus.lfsr_en         = (state_q == WARM) || (state_q == WR);
   assign bus.lfsr_tab        = tap_q;
   assign bus.lfsr_init_state = seed_q;
   assign bus.rd_addr         = idx_q;
   assign bus.wr_en           = state_q == WR;
   assign bus.wr_addr         = idx_q;
   assign bus.wr_data         = bus.rd_data ^ bus.lfsr_state;
   assign bus.busy            = state_q != IDLE;
   assign bus.done            = state_q == DONE;
endmodule
